sm_regread_arbiter: RTL
=======================

# sm_regread_arbiter

Shares the single combinational debug register-file read port of `sm_top` (`regAddr` → `regData`) between two requesters: a board display refresher and an optional host (debug-bridge) read port. The display side runs in one of two modes: manual, which reads a switch-selected register, or auto-scan, which steps through r0..`SCAN_LAST` with a programmable dwell time. The block sits between `sm_top` and the board-level display/LED logic and runs on the undivided board clock.

## Interface
Parameters:
- `DWELL_W`, default 25: width of the dwell counter.
- `DWELL`, default 25_000_000: dwell period in clocks, range 1..2^`DWELL_W`−1.
- `SCAN_LAST`, default 31: last register index visited by auto-scan, range 0..31.

Ports:
- `clkIn` input, 1 bit: the single clock. All state is on its rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `regAddr` output, 5 bits: register-file read address, driven to `sm_top`. Registered.
- `regData` input, 32 bits: register-file read data, combinational from `regAddr`.
- `scan_en` input, 1 bit: 1 selects auto-scan, 0 selects manual mode.
- `manual_addr` input, 5 bits: register displayed in manual mode.
- `disp_addr` output, 5 bits: address of the last completed display read.
- `disp_data` output, 32 bits: data of the last completed display read.
- `disp_valid` output, 1 bit: one-cycle pulse when `disp_addr`/`disp_data` update.
- `host_req` input, 1 bit: host read request. Level signal, held until `host_ack`.
- `host_addr` input, 5 bits: host read address. Must be stable while `host_req`=1.
- `host_ack` output, 1 bit: one-cycle pulse when `host_data` is valid.
- `host_data` output, 32 bits: host read result. Holds its value until the next ack.

## Operation
- FSM has two states: IDLE and SETTLE. Every read costs 2 cycles.
- IDLE behaviour:
  - If any request is pending, grant it: load `regAddr` with the granted address, record the grantee, and go to SETTLE.
  - If nothing is pending, stay in IDLE.
- SETTLE behaviour:
  - Capture `regData` into the grantee's data register and set its ack or valid flop for the next cycle.
  - Return to IDLE. `regAddr` holds its value until the next grant.
- Pending conditions:
  - Host is pending when `host_req`=1 and `host_ack`=0. Because of this, a request held through its ack cycle is not re-granted.
  - Display is pending when `disp_pend`=1.
- Arbitration:
  - When only one requester is pending, it wins.
  - When both are pending, the requester not granted last wins. `last_host` resets to 0, so the host wins the first tie.
- Dwell counter:
  - Counts 0..`DWELL`−1, then wraps to 0.
  - At terminal count it sets `disp_pend`.
  - At terminal count with `scan_en`=1 it also advances `scan_addr`: `SCAN_LAST` wraps to 0, and any value above `SCAN_LAST` also wraps to 0.
- Display address at grant: `scan_addr` if `scan_en`=1, otherwise `manual_addr`. The value is sampled at grant, not at terminal count.
- A change of `manual_addr` (compared against a registered copy) sets `disp_pend` immediately, regardless of `scan_en`.
- A change of `scan_en` resets the dwell counter to 0 and sets `disp_pend`.
- A display grant clears `disp_pend`. A new set event in the same cycle as the grant wins, so `disp_pend` stays 1.
- A terminal count while `disp_pend` is already 1 is not queued: only one pending read exists, and it uses the latest address.

## Timing
- Reset values (asynchronous):
  - All outputs are 0: `regAddr`, `disp_addr`, `disp_data`, `disp_valid`, `host_ack`, `host_data`.
  - Internal state: FSM in IDLE, counter 0, `scan_addr` 0, `last_host` 0.
  - `disp_pend` resets to 1, so r0 is displayed right after reset.
- Host latency: `host_req` high in IDLE at cycle N → `regAddr`=`host_addr` in N+1 → `host_ack`=1 with valid `host_data` in N+2.
- Host handshake: the host drops `host_req` in N+3 at the latest, or keeps it high to issue a back-to-back request, which is granted in N+3.
- Display latency follows the same pattern: `disp_pend` seen in IDLE at N → `disp_valid` pulse at N+2.
- Worst-case wait with both requesters saturating: 4 cycles from pending to grant.
- Reset asserted mid-read abandons the read; no ack or valid pulse is produced.
- `DWELL`=1: a terminal count every cycle, the display is permanently pending, and host and display alternate.

## Configuration
- Macro `SM_REGREAD_HOST_EN`.
- Defined: the host port operates as specified above.
- Undefined:
  - `host_req`/`host_addr` are ignored.
  - `host_ack` and `host_data` are tied to 0.
  - Only display reads occur; the arbitration logic and `last_host` are removed.

## Test plan
- Reset release with `scan_en`=0, `manual_addr`=0, `regData`=32'hA5A5_0000 → `regAddr`=0 and `disp_valid` pulse 2 cycles after release, with `disp_data`=32'hA5A5_0000 and `disp_addr`=0.
- Host read of r7, with the model returning 32'h0000_0700 for address 7 → `host_ack` exactly 2 cycles after `host_req`, `host_data`=32'h0000_0700, and `host_ack` high for one cycle only.
- `host_req` held high for 10 cycles with `host_addr`=3 → acks at cycles 2, 5 and 8 (re-grants spaced 3 cycles apart), with no double ack.
- `DWELL`=4, `SCAN_LAST`=2, `scan_en`=1, no host → `disp_addr` sequence 0,1,2,0,1, with one `disp_valid` every 4 cycles.
- `DWELL`=1, `scan_en`=0, host continuously requesting → grants alternate host/display/host, and both see valid pulses every 4 cycles.
- `rst_n` pulsed low during SETTLE of a host read → no `host_ack`, all outputs at 0 immediately, and the r0 display read follows after release.

Source files
------------

// File: rtl/sm_regread_arbiter.sv
// sm_regread_arbiter: shares the sm_top debug register-file read port
// between a display refresher (manual or auto-scan) and a host read port.
// Every read takes two cycles: IDLE grants and drives regAddr, SETTLE
// captures regData for the grantee.
// Optional host port: define SM_REGREAD_HOST_EN to enable it; otherwise
// host_req/host_addr are ignored and host_ack/host_data read as 0.
module sm_regread_arbiter #(
  parameter int unsigned DWELL_W   = 25,
  parameter int unsigned DWELL     = 25_000_000,
  parameter int unsigned SCAN_LAST = 31
) (
  input  logic        clkIn,
  input  logic        rst_n,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  input  logic        scan_en,
  input  logic [4:0]  manual_addr,
  output logic [4:0]  disp_addr,
  output logic [31:0] disp_data,
  output logic        disp_valid,
  input  logic        host_req,
  input  logic [4:0]  host_addr,
  output logic        host_ack,
  output logic [31:0] host_data
);

  typedef enum logic {IDLE, SETTLE} state_t;

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
  localparam logic [4:0]         SCAN_MAX   = 5'(SCAN_LAST);

  state_t             state, state_nxt;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [4:0]         scan_addr;
  logic               disp_pend;
  logic [4:0]         manual_q;
  logic               scan_en_q;
  logic               dwell_tc, scan_chg, manual_chg;
  logic [4:0]         disp_sel;
  logic               grant_host, grant_disp;
  logic [4:0]         grant_addr;
  logic               settle_host;

  assign dwell_tc   = (dwell_cnt == DWELL_LAST);
  assign scan_chg   = (scan_en != scan_en_q);
  assign manual_chg = (manual_addr != manual_q);
  assign disp_sel   = scan_en ? scan_addr : manual_addr;

`ifdef SM_REGREAD_HOST_EN
  logic host_pend;
  logic last_host;
  logic gnt_host;

  assign host_pend   = host_req & ~host_ack;
  assign settle_host = gnt_host;
`else
  logic host_unused;

  assign host_unused = ^{host_req, host_addr};
  assign settle_host = 1'b0;
  assign host_ack    = 1'b0;
  assign host_data   = '0;
`endif

  // FSM state register
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Grant decision and next state; host wins a tie unless it had the last grant
  always_comb begin
    state_nxt  = state;
    grant_host = 1'b0;
    grant_disp = 1'b0;
    grant_addr = disp_sel;
    if (state == IDLE) begin
`ifdef SM_REGREAD_HOST_EN
      if (host_pend && (!disp_pend || !last_host)) begin
        grant_host = 1'b1;
        grant_addr = host_addr;
      end else if (disp_pend) begin
        grant_disp = 1'b1;
      end
`else
      grant_disp = disp_pend;
`endif
      if (grant_host || grant_disp) state_nxt = SETTLE;
    end else begin
      state_nxt = IDLE;
    end
  end

  // Read address register and display-side capture
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      regAddr    <= '0;
      disp_addr  <= '0;
      disp_data  <= '0;
      disp_valid <= 1'b0;
    end else begin
      disp_valid <= 1'b0;
      if (grant_host || grant_disp) regAddr <= grant_addr;
      if (state == SETTLE && !settle_host) begin
        disp_addr  <= regAddr;
        disp_data  <= regData;
        disp_valid <= 1'b1;
      end
    end
  end

`ifdef SM_REGREAD_HOST_EN
  // Host-side grantee tracking, fairness memory and capture
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      gnt_host  <= 1'b0;
      last_host <= 1'b0;
      host_ack  <= 1'b0;
      host_data <= '0;
    end else begin
      host_ack <= 1'b0;
      if (grant_host || grant_disp) begin
        gnt_host  <= grant_host;
        last_host <= grant_host;
      end
      if (state == SETTLE && gnt_host) begin
        host_data <= regData;
        host_ack  <= 1'b1;
      end
    end
  end
`endif

  // Dwell counter, scan pointer and the single display-pending flag;
  // a set event in the grant cycle keeps the flag high
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      dwell_cnt <= '0;
      scan_addr <= '0;
      disp_pend <= 1'b1;
    end else begin
      if (scan_chg) begin
        dwell_cnt <= '0;
      end else if (dwell_tc) begin
        dwell_cnt <= '0;
        if (scan_en) scan_addr <= (scan_addr >= SCAN_MAX) ? '0 : scan_addr + 5'd1;
      end else begin
        dwell_cnt <= dwell_cnt + DWELL_W'(1);
      end
      if (dwell_tc || scan_chg || manual_chg) disp_pend <= 1'b1;
      else if (grant_disp)                    disp_pend <= 1'b0;
    end
  end

  // Change-detect copies run free through reset, so a level held
  // across reset release is not mistaken for a change
  always_ff @(posedge clkIn) begin
    manual_q  <= manual_addr;
    scan_en_q <= scan_en;
  end

endmodule
